// File: rtl/uart_io_queue_if.sv
// uart_io_queue_if
// CPU-side request/response bus of the UART I/O queue.
//   master : the execute stage; drives req_valid/req_write/req_word/req_wdata
//   slave  : uart_io_queue; drives req_ready/resp_valid/resp_rdata
// A request is accepted in the cycle where req_valid && req_ready.
interface uart_io_queue_if;
   logic        req_valid;
   logic        req_write;
   logic        req_word;
   logic [31:0] req_wdata;
   logic        req_ready;
   logic        resp_valid;
   logic [31:0] resp_rdata;

   modport master (
      output req_valid, req_write, req_word, req_wdata,
      input  req_ready, resp_valid, resp_rdata
   );

   modport slave (
      input  req_valid, req_write, req_word, req_wdata,
      output req_ready, resp_valid, resp_rdata
   );
endinterface

// File: rtl/uart_io_queue.sv
// uart_io_queue
// Byte queueing between the uart_rx/uart_tx cores and the CPU execute stage.
// Received bytes go into an RX ring buffer, OUT data into a TX ring buffer
// that is drained one byte per uart_tx frame. IN/OUT requests move one byte
// or a little-endian 32-bit word. In load mode the block sends SYNC_BYTE once.
// Ports:
//   clk, rstn      clock, synchronous active-low reset
//   mode           1 = LOAD (send sync), 2 = EXEC (capture RX)
//   rx_data/valid  byte strobe from uart_rx
//   tx_busy        uart_tx busy
//   tx_data/start  byte and one-cycle start strobe to uart_tx
//   cpu            CPU request bus (slave side)
//   sync_sent      sticky, SYNC_BYTE has been transmitted
//   sync_received  rx strobe carrying SYNC_BYTE (combinational)
//   rx_overflow    sticky, an RX byte was dropped on a full buffer
//   rx_count       bytes held in the RX buffer
//   tx_count       bytes held in the TX buffer
module uart_io_queue #(
   parameter int         RX_LOG2   = 11,
   parameter int         TX_LOG2   = 11,
   parameter logic [7:0] SYNC_BYTE = 8'hAA
) (
   input  logic               clk,
   input  logic               rstn,
   input  logic [2:0]         mode,
   input  logic [7:0]         rx_data,
   input  logic               rx_valid,
   input  logic               tx_busy,
   output logic [7:0]         tx_data,
   output logic               tx_start,
   uart_io_queue_if.slave     cpu,
   output logic               sync_sent,
   output logic               sync_received,
   output logic               rx_overflow,
   output logic [RX_LOG2:0]   rx_count,
   output logic [TX_LOG2:0]   tx_count
);

   localparam int RX_DEPTH = 1 << RX_LOG2;
   localparam int TX_DEPTH = 1 << TX_LOG2;
   localparam logic [RX_LOG2:0] RX_FULL = (RX_LOG2+1)'(RX_DEPTH);
   localparam logic [TX_LOG2:0] TX_FULL = (TX_LOG2+1)'(TX_DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_SEND, S_WAIT, S_DONE} sync_state_t;
   typedef enum logic [1:0] {D_IDLE, D_READ, D_START, D_GUARD} drain_state_t;
   typedef enum logic [1:0] {R_IDLE, R_IN_POP, R_IN_CAP, R_OUT} req_state_t;

   sync_state_t  s_state;
   drain_state_t d_state;
   req_state_t   r_state;

   logic [7:0]         rx_mem [RX_DEPTH];
   logic [7:0]         tx_mem [TX_DEPTH];
   logic [RX_LOG2-1:0] rx_wr_ptr, rx_rd_ptr;
   logic [TX_LOG2-1:0] tx_wr_ptr, tx_rd_ptr;
   logic [7:0]         rx_q, tx_q;

   logic        s_wait_first;
   logic [1:0]  req_idx;
   logic        req_is_word;
   logic [31:0] wdata_q;
   logic [31:0] in_acc;

   logic        rx_full, rx_empty, rx_push, rx_pop;
   logic        tx_full, tx_empty, tx_push, tx_pop;
   logic        req_last;
   logic [31:0] in_lane;
   logic [7:0]  out_byte;

   assign rx_full  = (rx_count == RX_FULL);
   assign rx_empty = (rx_count == '0);
   assign tx_full  = (tx_count == TX_FULL);
   assign tx_empty = (tx_count == '0);

   assign rx_push = (mode == 3'd2) && rx_valid && !rx_full;
   assign rx_pop  = (r_state == R_IN_POP) && !rx_empty;
   assign tx_push = (r_state == R_OUT) && !tx_full;
   // The drain never starts a frame while the sync handshake owns uart_tx.
   assign tx_pop  = (d_state == D_IDLE) && (mode != 3'd1) && !tx_empty && !tx_busy
                    && (s_state != S_SEND) && (s_state != S_WAIT);

   assign sync_received = rx_valid && (rx_data == SYNC_BYTE);

   assign req_last = !req_is_word || (req_idx == 2'd3);
   assign in_lane  = {24'b0, rx_q} << {req_idx, 3'b000};
   assign out_byte = wdata_q[{req_idx, 3'b000} +: 8];

   // Buffer storage: synchronous-read RAMs, contents are not reset.
   always_ff @(posedge clk) begin
      if (rx_push) rx_mem[rx_wr_ptr] <= rx_data;
      if (rx_pop)  rx_q <= rx_mem[rx_rd_ptr];
      if (tx_push) tx_mem[tx_wr_ptr] <= out_byte;
      if (tx_pop)  tx_q <= tx_mem[tx_rd_ptr];
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         rx_wr_ptr   <= '0;
         rx_rd_ptr   <= '0;
         rx_count    <= '0;
         rx_overflow <= 1'b0;
      end else begin
         if (rx_push) rx_wr_ptr <= rx_wr_ptr + RX_LOG2'(1);
         if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + RX_LOG2'(1);
         case ({rx_push, rx_pop})
            2'b10:   rx_count <= rx_count + (RX_LOG2+1)'(1);
            2'b01:   rx_count <= rx_count - (RX_LOG2+1)'(1);
            default: rx_count <= rx_count;
         endcase
         // Full is judged on the pre-cycle count, so a same-cycle pop does not save the byte.
         if ((mode == 3'd2) && rx_valid && rx_full) rx_overflow <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         tx_wr_ptr <= '0;
         tx_rd_ptr <= '0;
         tx_count  <= '0;
      end else begin
         if (tx_push) tx_wr_ptr <= tx_wr_ptr + TX_LOG2'(1);
         if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + TX_LOG2'(1);
         case ({tx_push, tx_pop})
            2'b10:   tx_count <= tx_count + (TX_LOG2+1)'(1);
            2'b01:   tx_count <= tx_count - (TX_LOG2+1)'(1);
            default: tx_count <= tx_count;
         endcase
      end
   end

   // Sync and drain FSMs share the uart_tx outputs, so they live together.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         s_state      <= S_IDLE;
         s_wait_first <= 1'b0;
         d_state      <= D_IDLE;
         tx_start     <= 1'b0;
         tx_data      <= 8'h00;
         sync_sent    <= 1'b0;
      end else begin
         tx_start <= 1'b0;

         case (s_state)
            S_IDLE: begin
               // Waiting for an in-flight drain frame keeps the two strobes apart.
               if ((mode == 3'd1) && !sync_sent && (d_state == D_IDLE)) begin
                  tx_start <= 1'b1;
                  tx_data  <= SYNC_BYTE;
                  s_state  <= S_SEND;
               end
            end
            S_SEND: begin
               s_wait_first <= 1'b1;
               s_state      <= S_WAIT;
            end
            S_WAIT: begin
               // uart_tx raises busy a cycle after the strobe; skip that cycle.
               if (s_wait_first) begin
                  s_wait_first <= 1'b0;
               end else if (!tx_busy) begin
                  sync_sent <= 1'b1;
                  s_state   <= S_DONE;
               end
            end
            S_DONE: s_state <= S_DONE;
         endcase

         case (d_state)
            D_IDLE:  if (tx_pop) d_state <= D_READ;
            D_READ: begin
               tx_start <= 1'b1;
               tx_data  <= tx_q;
               d_state  <= D_START;
            end
            D_START: d_state <= D_GUARD;
            // Gives uart_tx time to raise busy before the next pop decision.
            D_GUARD: d_state <= D_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_state        <= R_IDLE;
         cpu.req_ready  <= 1'b1;
         cpu.resp_valid <= 1'b0;
         cpu.resp_rdata <= 32'h0;
         req_idx        <= 2'd0;
         req_is_word    <= 1'b0;
         wdata_q        <= 32'h0;
         in_acc         <= 32'h0;
      end else begin
         cpu.resp_valid <= 1'b0;
         case (r_state)
            R_IDLE: begin
               if (cpu.req_valid) begin
                  cpu.req_ready <= 1'b0;
                  req_is_word   <= cpu.req_word;
                  req_idx       <= 2'd0;
                  in_acc        <= 32'h0;
                  wdata_q       <= cpu.req_wdata;
                  r_state       <= cpu.req_write ? R_OUT : R_IN_POP;
               end
            end
            R_IN_POP: if (!rx_empty) r_state <= R_IN_CAP;
            R_IN_CAP: begin
               if (req_last) begin
                  cpu.resp_rdata <= in_acc | in_lane;
                  cpu.resp_valid <= 1'b1;
                  cpu.req_ready  <= 1'b1;
                  r_state        <= R_IDLE;
               end else begin
                  in_acc  <= in_acc | in_lane;
                  req_idx <= req_idx + 2'd1;
                  r_state <= R_IN_POP;
               end
            end
            R_OUT: begin
               if (!tx_full) begin
                  if (req_last) begin
                     cpu.req_ready <= 1'b1;
                     r_state       <= R_IDLE;
                  end else begin
                     req_idx <= req_idx + 2'd1;
                  end
               end
            end
         endcase
      end
   end

endmodule
